if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response and the
// IF/ID handoff. Every channel is valid/ready: a transfer happens in a cycle where
// both are high. Valid never depends on ready. The payload stays stable while valid && !ready.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        output id_valid, id_pc, id_inst, id_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  id_valid, id_pc, id_inst, id_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, a single-entry output
// buffer toward decode, and redirect handling that cancels in-flight fetches.
module if_stage #(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] pc_plus4,
    output logic        stall_pc,
    output logic [1:0]  dbg_state,
    if_stage_if.master  bus
);
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_OUT = 2'd2, S_DROP = 2'd3} state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_fault_q, id_fault_d;
    logic        misaligned;

    assign misaligned = |pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            req_pc_q   <= 32'd0;
            id_pc_q    <= 32'd0;
            id_inst_q  <= NOP;
            id_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_fault_q <= id_fault_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        req_pc_d           = req_pc_q;
        id_pc_d            = id_pc_q;
        id_inst_d          = id_inst_q;
        id_fault_d         = id_fault_q;
        bus.imem_req_valid = 1'b0;
        bus.id_valid       = 1'b0;
        // The PC only moves on a handoff to decode or on a redirect.
        stall_pc           = !flush && !(state_q == S_OUT && bus.id_ready);

        unique case (state_q)
            S_REQ: begin
                if (!flush) begin
                    if (misaligned) begin
                        id_pc_d    = pc;
                        id_inst_d  = NOP;
                        id_fault_d = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        bus.imem_req_valid = 1'b1;
                        if (bus.imem_req_ready) begin
                            req_pc_d = pc;
                            state_d  = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = bus.imem_rsp_valid ? S_REQ : S_DROP;
                end else if (bus.imem_rsp_valid) begin
                    id_pc_d    = req_pc_q;
                    id_inst_d  = bus.imem_rsp_data;
                    id_fault_d = 1'b0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                bus.id_valid = !flush;
                if (flush || bus.id_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // A cancelled request must still drain before a new one is issued.
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign pc_plus4           = pc + 32'd4;
    assign bus.imem_req_addr  = pc;
    assign bus.imem_rsp_ready = 1'b1;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_fault       = id_fault_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reset/combinational vector table, directed multi-cycle
// sequences, and a randomized run against a flag-based fetch model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] pc_plus4;
  logic        stall_pc;
  logic [1:0]  dbg_state;

  if_stage_if bus();

  if_stage #(.NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush),
    .pc_plus4(pc_plus4), .stall_pc(stall_pc), .dbg_state(dbg_state),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] p, input logic fl, input logic rq_rdy,
                        input logic rs_v, input logic [31:0] rs_d, input logic id_rdy);
    pc = p;
    flush = fl;
    bus.imem_req_ready = rq_rdy;
    bus.imem_rsp_valid = rs_v;
    bus.imem_rsp_data = rs_d;
    bus.id_ready = id_rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // ---------------- vector table (state held in REQ by reset) ----------------
  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic [31:0] e_plus4;
    logic        e_req_valid;
    logic        e_stall;
  } vec_t;

  vec_t vecs[6];

  // ---------------- random-run model ----------------
  logic [31:0] m_pc, mem_addr, tgt;
  bit m_buf, m_inflight, m_dead, mem_busy;
  int mem_cnt, handoffs;

  initial begin
    vecs[0] = '{32'h8000_0000, 1'b0, 32'h8000_0004, 1'b1, 1'b1};
    vecs[1] = '{32'h8000_0000, 1'b1, 32'h8000_0004, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h8000_0002, 1'b0, 32'h8000_0006, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0001, 1'b1, 32'h0000_0005, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0003, 1'b0, 1'b1};

    do_reset();
    rst = 1'b1;
    #1;
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    chk("reset_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("reset_id_pc", bus.id_pc, 32'd0);
    chk("reset_id_inst", bus.id_inst, NOP);
    chk("reset_id_fault", {31'd0, bus.id_fault}, 32'd0);
    chk("rsp_ready", {31'd0, bus.imem_rsp_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].pc, vecs[i].flush, 1'b1, 1'b0, 32'd0, 1'b1);
      #1;
      chk("vec_plus4", pc_plus4, vecs[i].e_plus4);
      chk("vec_req_valid", {31'd0, bus.imem_req_valid}, {31'd0, vecs[i].e_req_valid});
      chk("vec_stall", {31'd0, stall_pc}, {31'd0, vecs[i].e_stall});
      if (vecs[i].e_req_valid) chk("vec_req_addr", bus.imem_req_addr, vecs[i].pc);
    end
    tick();

    // ---- sequential fetch, zero-wait memory ----
    do_reset();
    set_in(32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); #1;
    chk("seq_c0_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("seq_c0_addr", bus.imem_req_addr, 32'h8000_0000);
    tick();
    set_in(32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h0010_0093, 1'b1); #1;
    chk("seq_c1_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("seq_c1_stall", {31'd0, stall_pc}, 32'd1);
    tick();
    set_in(32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); #1;
    chk("seq_c2_id_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("seq_c2_id_pc", bus.id_pc, 32'h8000_0000);
    chk("seq_c2_id_inst", bus.id_inst, 32'h0010_0093);
    chk("seq_c2_stall", {31'd0, stall_pc}, 32'd0);
    tick();
    set_in(32'h8000_0004, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); #1;
    chk("seq_c3_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("seq_c3_addr", bus.imem_req_addr, 32'h8000_0004);
    tick();

    // ---- request and decode backpressure, stray response in OUT ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0); #1;
      chk("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("bp_req_addr", bus.imem_req_addr, 32'h8000_0010);
      chk("bp_req_stall", {31'd0, stall_pc}, 32'd1);
      tick();
    end
    set_in(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0); #1;
    chk("bp_req_valid_hs", {31'd0, bus.imem_req_valid}, 32'd1);
    tick();
    set_in(32'h8000_0010, 1'b0, 1'b0, 1'b1, 32'h00a0_0513, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      set_in(32'h8000_0010, 1'b0, 1'b0, (i == 0), 32'hFFFF_FFFF, 1'b0); #1;
      chk("bp_out_valid", {31'd0, bus.id_valid}, 32'd1);
      chk("bp_out_pc", bus.id_pc, 32'h8000_0010);
      chk("bp_out_inst", bus.id_inst, 32'h00a0_0513);
      chk("bp_out_stall", {31'd0, stall_pc}, 32'd1);
      chk("bp_out_state", {30'd0, dbg_state}, 32'd2);
      tick();
    end
    set_in(32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1); #1;
    chk("bp_handoff_stall", {31'd0, stall_pc}, 32'd0);
    chk("bp_handoff_inst", bus.id_inst, 32'h00a0_0513);
    tick();
    chk("bp_after_state", {30'd0, dbg_state}, 32'd0);

    // ---- flush in WAIT, 4-cycle memory latency ----
    do_reset();
    set_in(32'h8000_0020, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); tick();
    set_in(32'h8000_0020, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1); #1;
    chk("fw_flush_stall", {31'd0, stall_pc}, 32'd0);
    chk("fw_flush_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(32'h8000_0100, 1'b0, 1'b1, (i == 2), 32'h1111_1111, 1'b1); #1;
      chk("fw_drop_id_valid", {31'd0, bus.id_valid}, 32'd0);
      chk("fw_drop_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("fw_drop_stall", {31'd0, stall_pc}, 32'd1);
      tick();
    end
    set_in(32'h8000_0100, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); #1;
    chk("fw_new_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("fw_new_addr", bus.imem_req_addr, 32'h8000_0100);
    chk("fw_no_old_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    set_in(32'h8000_0100, 1'b0, 1'b1, 1'b1, 32'h2222_2293, 1'b0); tick();

    // ---- flush in OUT ----
    set_in(32'h8000_0100, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0); #1;
    chk("fo_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("fo_pc", bus.id_pc, 32'h8000_0100);
    chk("fo_inst", bus.id_inst, 32'h2222_2293);
    tick();
    set_in(32'h8000_0100, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0); #1;
    chk("fo_kill_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("fo_kill_stall", {31'd0, stall_pc}, 32'd0);
    tick();
    set_in(32'h8000_0200, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0); #1;
    chk("fo_next_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("fo_restart_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("fo_restart_addr", bus.imem_req_addr, 32'h8000_0200);
    tick();

    // ---- misaligned PC ----
    do_reset();
    set_in(32'h8000_0002, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0); #1;
    chk("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick(); #1;
    chk("mis_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("mis_fault", {31'd0, bus.id_fault}, 32'd1);
    chk("mis_inst", bus.id_inst, NOP);
    chk("mis_pc", bus.id_pc, 32'h8000_0002);
    chk("mis_no_req_out", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();

    // ---- reset during WAIT after a completed fetch ----
    do_reset();
    set_in(32'h8000_0040, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); tick();
    set_in(32'h8000_0040, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b1); tick();
    set_in(32'h8000_0040, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); tick();
    set_in(32'h8000_0044, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1); tick();
    #1;
    chk("rw_in_wait", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rw_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rw_id_inst", bus.id_inst, NOP);
    chk("rw_id_pc", bus.id_pc, 32'd0);
    chk("rw_state", {30'd0, dbg_state}, 32'd0);
    chk("rw_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rw_req_addr", bus.imem_req_addr, 32'h8000_0044);
    tick();

    // ---- randomized run against the fetch model ----
    do_reset();
    m_pc = 32'h8000_0000;
    m_buf = 0; m_inflight = 0; m_dead = 0; mem_busy = 0; mem_cnt = 0; handoffs = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_idv, e_rv, e_st, hs, rsp, handoff;
      logic fl, rq_rdy, id_rdy;
      fl = ($urandom_range(0, 11) == 0);
      rq_rdy = ($urandom_range(0, 3) != 0);
      id_rdy = ($urandom_range(0, 3) != 0);
      tgt = {16'h8000, 16'($urandom_range(0, 16'hFFFF))} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      rsp = mem_busy && (mem_cnt == 0);
      set_in(m_pc, fl, rq_rdy, rsp, rsp ? mem_word(mem_addr) : $urandom, id_rdy);
      #1;
      e_idv = m_buf && !fl;
      e_rv = !m_buf && !m_inflight && (m_pc[1:0] == 2'b00) && !fl;
      e_st = !fl && !(m_buf && id_rdy);
      chk("rnd_id_valid", {31'd0, bus.id_valid}, {31'd0, e_idv});
      chk("rnd_req_valid", {31'd0, bus.imem_req_valid}, {31'd0, e_rv});
      chk("rnd_stall", {31'd0, stall_pc}, {31'd0, e_st});
      chk("rnd_plus4", pc_plus4, m_pc + 32'd4);
      if (e_rv) chk("rnd_req_addr", bus.imem_req_addr, m_pc);
      if (e_idv) begin
        chk("rnd_id_pc", bus.id_pc, m_pc);
        chk("rnd_id_fault", {31'd0, bus.id_fault}, {31'd0, (m_pc[1:0] != 2'b00)});
        chk("rnd_id_inst", bus.id_inst, exp_q[0]);
      end

      hs = e_rv && rq_rdy;
      handoff = e_idv && id_rdy;
      if (rsp) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (hs) begin
        mem_busy = 1;
        mem_addr = m_pc;
        mem_cnt = $urandom_range(0, 3);
      end

      if (fl) begin
        if (m_buf) begin m_buf = 0; void'(exp_q.pop_front()); end
        if (m_inflight) begin
          if (rsp) m_inflight = 0;
          else m_dead = 1;
        end
        m_pc = tgt;
      end else begin
        if (handoff) begin
          m_buf = 0;
          void'(exp_q.pop_front());
          handoffs++;
          m_pc = m_pc + 32'd4;
        end else if (m_inflight && rsp) begin
          m_inflight = 0;
          if (!m_dead) begin m_buf = 1; exp_q.push_back(mem_word(m_pc)); end
          m_dead = 0;
        end else if (!m_buf && !m_inflight && (m_pc[1:0] != 2'b00)) begin
          m_buf = 1;
          exp_q.push_back(NOP);
        end
        if (hs) begin m_inflight = 1; m_dead = 0; end
      end
      tick();
    end
    chk("rnd_progress", {31'd0, (handoffs >= 50)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
